// File: rtl/nibble_stream_reader_if.sv
// nibble_stream_reader_if
//   Nibble-wide valid/ready stream between a nibble source and its consumer.
//   nib_valid : source has a nibble on nib_data awaiting acceptance
//   nib_ready : consumer accepts the current nibble this cycle
//   nib_data  : 4-bit payload, 0 whenever nib_valid is low
//   nib_last  : marks the final nibble of a request
//   master    : nibble source side
//   slave     : nibble consumer side
interface nibble_stream_reader_if;
  logic       nib_valid;
  logic       nib_ready;
  logic [3:0] nib_data;
  logic       nib_last;

  modport master (
    output nib_valid,
    output nib_data,
    output nib_last,
    input  nib_ready
  );

  modport slave (
    input  nib_valid,
    input  nib_data,
    input  nib_last,
    output nib_ready
  );
endinterface

// File: rtl/nibble_stream_reader.sv
// nibble_stream_reader
//   On an enabled start in IDLE, snapshots NIBBLES 4-bit register values and
//   streams them out most-significant nibble first, one per accepted transfer.
//   Ports:
//     clk     : system clock, rising edge
//     clr     : synchronous active-high reset, aborts any stream in progress
//     enable  : qualifies start
//     start   : capture data_in and begin streaming (honoured only in IDLE)
//     data_in : 4*NIBBLES concatenated values, nibble NIBBLES-1 on top
//     nib     : nibble stream source (valid/ready/data/last)
//     busy    : high from the capture edge until DONE is left
//     done    : one-cycle pulse after the last nibble is accepted
module nibble_stream_reader #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   enable,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   data_in,
  nibble_stream_reader_if.master nib,
  output logic                   busy,
  output logic                   done
);

  // idx needs at least one bit even when only a single nibble is streamed.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [4*NIBBLES-1:0]   shadow;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;

  // Nibble at stream position i; position 0 is the most significant nibble.
  function automatic logic [3:0] nib_sel(input logic [4*NIBBLES-1:0] v,
                                         input logic [IDX_W-1:0]     i);
    return v[4*(NIBBLES-1-int'(i)) +: 4];
  endfunction

  assign idx_nxt = idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      shadow        <= '0;
      idx           <= '0;
      nib.nib_valid <= 1'b0;
      nib.nib_data  <= 4'h0;
      nib.nib_last  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          nib.nib_valid <= 1'b0;
          nib.nib_data  <= 4'h0;
          nib.nib_last  <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
          if (start && enable) begin
            // Present the first nibble straight from data_in so it shows
            // in the cycle right after the capture edge.
            state         <= SEND;
            shadow        <= data_in;
            idx           <= '0;
            nib.nib_valid <= 1'b1;
            nib.nib_data  <= nib_sel(data_in, IDX_W'(0));
            nib.nib_last  <= (LAST_IDX == IDX_W'(0));
            busy          <= 1'b1;
          end
        end

        SEND: begin
          if (nib.nib_valid && nib.nib_ready) begin
            if (idx == LAST_IDX) begin
              state         <= DONE;
              nib.nib_valid <= 1'b0;
              nib.nib_data  <= 4'h0;
              nib.nib_last  <= 1'b0;
              done          <= 1'b1;
            end else begin
              idx           <= idx_nxt;
              nib.nib_data  <= nib_sel(shadow, idx_nxt);
              nib.nib_last  <= (idx_nxt == LAST_IDX);
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          nib.nib_valid <= 1'b0;
          nib.nib_data  <= 4'h0;
          nib.nib_last  <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule
